// File: rtl/okpipe_dispatch_pkg.sv
// Shared types and header field positions for the input-pipe dispatcher.
//   state_e        : dispatcher FSM state
//   HDR_CH_L/H     : channel field of a header word
//   HDR_LEN_L/H    : payload length field of a header word
package okpipe_dispatch_pkg;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  localparam int HDR_CH_L  = 16;
  localparam int HDR_CH_H  = 23;
  localparam int HDR_LEN_L = 0;
  localparam int HDR_LEN_H = 15;

endpackage

// File: rtl/okpipe_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   clk, rst_n   : clock, synchronous active-low reset (pointers/count only)
//   wr_en/wr_data: push request; accepted when not full, or full with a pop this cycle
//   rd_en        : pop request; ignored while empty
//   rd_data      : current head word, valid whenever !empty
//   empty/full   : occupancy flags
//   free_count   : DEPTH - occupancy
module okpipe_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   free_count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign empty      = (count_q == '0);
  assign full       = (count_q == (AW+1)'(DEPTH));
  assign free_count = (AW+1)'(DEPTH) - count_q;
  assign rd_data    = mem_q[rd_ptr_q];

  always_comb begin
    do_rd    = rd_en && !empty;
    // a full buffer still takes a word if the head leaves this cycle
    do_wr    = wr_en && (!full || do_rd);
    // DEPTH is a power of two, so pointers wrap by natural overflow
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/okpipe_in_dispatch.sv
// Input-pipe dispatcher: buffers pipe words and routes framed packets
// (header + LEN payload words) to one of N_CH valid/ready consumers.
//   ti_clk, ti_reset_n      : clock, synchronous active-low reset
//   pipe_write, pipe_data   : word strobe / data from the pipe endpoint
//   pipe_ready              : registered, buffer free >= READY_THRESH
//   ch_valid/ch_ready       : per-channel handshake (ch_valid one-hot)
//   ch_data, ch_last        : shared payload word, final-word marker
//   busy                    : packet in progress or buffer not empty
//   err_bad_ch, err_overflow: sticky errors, cleared by err_clear
module okpipe_in_dispatch
  import okpipe_dispatch_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int READY_THRESH = 8
) (
  input  logic            ti_clk,
  input  logic            ti_reset_n,
  input  logic            pipe_write,
  input  logic [31:0]     pipe_data,
  output logic            pipe_ready,
  output logic [N_CH-1:0] ch_valid,
  input  logic [N_CH-1:0] ch_ready,
  output logic [31:0]     ch_data,
  output logic            ch_last,
  output logic            busy,
  output logic            err_bad_ch,
  output logic            err_overflow,
  input  logic            err_clear
);

  localparam int         AW     = $clog2(FIFO_DEPTH);
  localparam int         CW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [7:0] N_CH_B = 8'(N_CH);

  logic [31:0]   head;
  logic          empty, full, pop, wr_acc, bad_set, ovf_set;
  logic [AW:0]   free_count, free_nxt;
  logic [7:0]    hdr_ch;
  logic [15:0]   hdr_len;

  state_e        state_q, state_d;
  logic [15:0]   rem_q, rem_d;
  logic [CW-1:0] sel_q, sel_d;
  logic          bad_q, bad_d;
  logic          ovf_q, ovf_d;
  logic          prdy_q, prdy_d;

  okpipe_sync_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk        (ti_clk),
    .rst_n      (ti_reset_n),
    .wr_en      (pipe_write),
    .wr_data    (pipe_data),
    .rd_en      (pop),
    .rd_data    (head),
    .empty      (empty),
    .full       (full),
    .free_count (free_count)
  );

  assign hdr_ch  = head[HDR_CH_H:HDR_CH_L];
  assign hdr_len = head[HDR_LEN_H:HDR_LEN_L];

  // head only moves on a transfer, so valid is held until accepted
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_valid[i] = (state_q == S_PAY) && !empty && (sel_q == CW'(i));
  end

  assign ch_data      = (|ch_valid) ? head : '0;
  assign ch_last      = (|ch_valid) && (rem_q == 16'd1);
  assign busy         = (state_q != S_HDR) || !empty;
  assign pipe_ready   = prdy_q;
  assign err_bad_ch   = bad_q;
  assign err_overflow = ovf_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    pop     = 1'b0;
    bad_set = 1'b0;
    unique case (state_q)
      S_HDR: begin
        if (!empty) begin
          pop   = 1'b1;
          rem_d = hdr_len;
          sel_d = hdr_ch[CW-1:0];
          // zero-length packets carry nothing, so the channel is not checked
          if (hdr_len == 16'd0) begin
            state_d = S_HDR;
          end else if (hdr_ch < N_CH_B) begin
            state_d = S_PAY;
          end else begin
            bad_set = 1'b1;
            state_d = S_DROP;
          end
        end
      end
      S_PAY: begin
        if (|(ch_valid & ch_ready)) begin
          pop   = 1'b1;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_HDR;
        end
      end
      S_DROP: begin
        if (!empty) begin
          pop   = 1'b1;
          rem_d = rem_q - 16'd1;
          if (rem_q == 16'd1) state_d = S_HDR;
        end
      end
      default: state_d = S_HDR;
    endcase

    ovf_set  = pipe_write && full && !pop;
    wr_acc   = pipe_write && (!full || pop);
    free_nxt = free_count - (AW+1)'(wr_acc) + (AW+1)'(pop);
    prdy_d   = (free_nxt >= (AW+1)'(READY_THRESH));
    // a new error in the same cycle as err_clear keeps the flag set
    bad_d    = bad_set | (bad_q & ~err_clear);
    ovf_d    = ovf_set | (ovf_q & ~err_clear);
  end

  always_ff @(posedge ti_clk) begin
    if (!ti_reset_n) begin
      state_q <= S_HDR;
      rem_q   <= '0;
      sel_q   <= '0;
      bad_q   <= 1'b0;
      ovf_q   <= 1'b0;
      prdy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      bad_q   <= bad_d;
      ovf_q   <= ovf_d;
      prdy_q  <= prdy_d;
    end
  end

endmodule

// File: tb/tb_okpipe_in_dispatch.sv
module tb_okpipe_in_dispatch;
  localparam int N_CH   = 4;
  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic            ti_clk = 1'b0;
  logic            ti_reset_n = 1'b0;
  logic            pipe_write = 1'b0;
  logic [31:0]     pipe_data = '0;
  logic            pipe_ready;
  logic [N_CH-1:0] ch_valid;
  logic [N_CH-1:0] ch_ready = '0;
  logic [31:0]     ch_data;
  logic            ch_last, busy, err_bad_ch, err_overflow;
  logic            err_clear = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [7:0]  ch;
    logic [31:0] data;
    logic        last;
  } xfer_t;

  xfer_t           exp_q[$];   // expected transfers, derived from packets sent
  logic [31:0]     pay_q[$];   // preset payload words (random when empty)
  logic            exp_bad   = 1'b0;
  logic            rnd_ready = 1'b0;
  logic            stall_pend = 1'b0;
  logic [N_CH-1:0] stall_v;
  logic [31:0]     stall_d;

  always #5 ti_clk = ~ti_clk;

  okpipe_in_dispatch #(.N_CH(N_CH), .FIFO_DEPTH(DEPTH), .READY_THRESH(THRESH)) dut (
    .ti_clk       (ti_clk),
    .ti_reset_n   (ti_reset_n),
    .pipe_write   (pipe_write),
    .pipe_data    (pipe_data),
    .pipe_ready   (pipe_ready),
    .ch_valid     (ch_valid),
    .ch_ready     (ch_ready),
    .ch_data      (ch_data),
    .ch_last      (ch_last),
    .busy         (busy),
    .err_bad_ch   (err_bad_ch),
    .err_overflow (err_overflow),
    .err_clear    (err_clear)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N_CH-1:0] v);
    for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One clock: sample at negedge (monitor + stall rule), then advance to posedge+1.
  task automatic cyc();
    xfer_t e;
    @(negedge ti_clk);
    if (stall_pend) begin
      chk("stall_valid", ch_valid, stall_v);
      chk("stall_data", ch_data, stall_d);
    end
    if (|(ch_valid & ch_ready)) begin
      chk("onehot", $countones(ch_valid), 1);
      chk("xfer_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("xfer_ch", oh2idx(ch_valid), e.ch);
        chk("xfer_data", ch_data, e.data);
        chk("xfer_last", ch_last, e.last);
      end
    end
    stall_pend = (|ch_valid) && !(|(ch_valid & ch_ready));
    stall_v = ch_valid;
    stall_d = ch_data;
    @(posedge ti_clk);
    #1;
    if (rnd_ready) ch_ready = N_CH'($urandom);
  endtask

  task automatic put(input logic [31:0] w);
    pipe_write = 1'b1;
    pipe_data  = w;
    cyc();
    pipe_write = 1'b0;
  endtask

  task automatic wait_room();
    int b = 0;
    while (!pipe_ready && b < 300) begin cyc(); b++; end
    chk("pipe_ready_wait", pipe_ready, 1);
  endtask

  // Send one framed packet; expected deliveries come straight from the framing rules.
  task automatic send_pkt(input int ch, input int len);
    logic [31:0] w;
    if (!pipe_ready) wait_room();
    put({8'($urandom), 8'(ch), 16'(len)});
    if (len > 0 && ch >= N_CH) exp_bad = 1'b1;
    for (int i = 0; i < len; i++) begin
      w = (pay_q.size() != 0) ? pay_q.pop_front() : $urandom;
      if (ch < N_CH) exp_q.push_back('{ch: 8'(ch), data: w, last: (i == len - 1)});
      if (!pipe_ready) wait_room();
      put(w);
    end
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || busy) && b < 1000) begin cyc(); b++; end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_busy", busy, 0);
  endtask

  task automatic do_reset();
    ti_reset_n = 1'b0;
    pipe_write = 1'b0;
    @(posedge ti_clk);
    #1;
    ti_reset_n = 1'b1;
    exp_q.delete();
    stall_pend = 1'b0;
    exp_bad = 1'b0;
    @(negedge ti_clk);
    chk("rst_valid", ch_valid, 0);
    chk("rst_last", ch_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pready", pipe_ready, 1);
    chk("rst_bad", err_bad_ch, 0);
    chk("rst_ovf", err_overflow, 0);
    @(posedge ti_clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    @(posedge ti_clk);
    #1;
    do_reset();

    // ch1 LEN3, fixed payload, always ready
    ch_ready = '1;
    pay_q = '{32'h11, 32'h22, 32'h33};
    send_pkt(1, 3);
    drain();

    // ch0 LEN2 with ch0 back-pressured for 5 cycles
    ch_ready = 4'b1110;
    pay_q = '{32'hA1, 32'hA2};
    send_pkt(0, 2);
    repeat (5) cyc();
    chk("hold_valid", ch_valid, 4'b0001);
    chk("hold_data", ch_data, 32'hA1);
    chk("hold_busy", busy, 1);
    ch_ready = '1;
    drain();

    // bad channel packet dropped, following packet delivered
    send_pkt(9, 2);
    pay_q = '{32'h5A};
    send_pkt(2, 1);
    drain();
    chk("bad_ch_set", err_bad_ch, exp_bad);
    err_clear = 1'b1;
    cyc();
    err_clear = 1'b0;
    exp_bad = 1'b0;
    chk("bad_ch_clr", err_bad_ch, 0);

    // zero-length header then ch3 LEN1
    send_pkt(3, 0);
    pay_q = '{32'h77};
    send_pkt(3, 1);
    drain();

    // fill with consumers stalled: threshold and overflow boundaries
    ch_ready = '0;
    put({8'h00, 8'h00, 16'd100});
    for (int k = 1; k <= 20; k++) begin
      put(32'h1000 + 32'(k));
      cnt = (k < DEPTH) ? k : DEPTH;
      chk("fill_pready", pipe_ready, (DEPTH - cnt) >= THRESH);
      chk("fill_ovf", err_overflow, k > DEPTH);
    end
    chk("fill_valid", ch_valid, 4'b0001);
    chk("fill_head", ch_data, 32'h1001);
    do_reset();

    // reset in the middle of a ch0 LEN4 packet after 2 words
    ch_ready = '1;
    exp_q.push_back('{ch: 8'd0, data: 32'hB1, last: 1'b0});
    exp_q.push_back('{ch: 8'd0, data: 32'hB2, last: 1'b0});
    put({8'h00, 8'h00, 16'd4});
    put(32'hB1);
    put(32'hB2);
    repeat (3) cyc();
    chk("mid_left", exp_q.size(), 0);
    chk("mid_busy", busy, 1);
    do_reset();
    pay_q = '{32'hC1, 32'hC2};
    send_pkt(2, 2);
    drain();

    // randomized packets and back-pressure
    rnd_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int ch, len;
      ch  = $urandom_range(0, 5);
      if (ch == 5) ch = $urandom_range(5, 255);
      len = $urandom_range(0, 6);
      send_pkt(ch, len);
    end
    drain();
    rnd_ready = 1'b0;
    chk("rnd_bad", err_bad_ch, exp_bad);
    chk("rnd_ovf", err_overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
